// File: rtl/obi_pkg.sv
// Shared OBI definitions for the outstanding buffer.
//   obi_req_t     : one request FIFO entry {addr, we, be, wdata}. It is sized for
//                   the widest supported bus (64-bit address, 256-bit data).
//                   Narrower instances zero-extend into it and slice out of it.
//                   Constant-zero storage bits are left for synthesis to remove.
//   OBI_DEADBEEF  : 32-bit fill word returned with a timed-out response.
package obi_pkg;

  localparam int OBI_ADDR_MAX = 64;
  localparam int OBI_DATA_MAX = 256;
  localparam int OBI_BE_MAX   = OBI_DATA_MAX / 8;

  localparam logic [31:0] OBI_DEADBEEF = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [OBI_ADDR_MAX-1:0] addr;
    logic                    we;
    logic [OBI_BE_MAX-1:0]   be;
    logic [OBI_DATA_MAX-1:0] wdata;
  } obi_req_t;

endpackage

// File: rtl/obi_sync_fifo.sv
// Single-clock request FIFO with show-ahead head output.
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset (empties the FIFO)
//   push_i, data_i   : write strobe and entry; ignored while full
//   pop_i            : consume the head entry; ignored while empty
//   data_o           : head entry, valid while !empty_o
//   full_o, empty_o  : occupancy flags
// DEPTH must be a power of two, so the pointers wrap by natural overflow.
module obi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    cnt;
  logic             do_push, do_pop;

  assign full_o  = (cnt == CW'(DEPTH));
  assign empty_o = (cnt == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem[rptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by cnt.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= data_i;
  end

endmodule

// File: rtl/obi_outstanding_buffer.sv
// OBI outstanding-transaction buffer between a primary (ctrl) and a secondary
// port.
// Accepted requests are queued in a FIFO and replayed on the secondary port.
// Secondary responses are registered and returned in order on ctrl.
// Ports:
//   clk_i, rst_i               : clock, synchronous active-high reset
//   ctrl_req_i / ctrl_gnt_o    : primary handshake. The grant is combinational.
//   ctrl_addr_i/we_i/be_i/wdata_i : primary request fields
//   ctrl_rvalid_o/rdata_o/err_o   : primary response, registered
//   secondary_req_o / gnt_i    : secondary handshake, driven from the FIFO head
//   secondary_addr_o/we_o/be_o/wdata_o : FIFO head fields
//   secondary_rvalid_i/rdata_i : secondary response
// Optional feature: define OBI_BUF_TIMEOUT_EN to enable the response timeout.
// If TIMEOUT_CYCLES cycles pass with transactions issued and no response
// accepted, the buffer synthesises an error response that carries the
// DEADBEEF fill.
module obi_outstanding_buffer
  import obi_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int DEPTH           = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ctrl_req_i,
  output logic                    ctrl_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   ctrl_addr_i,
  input  logic                    ctrl_we_i,
  input  logic [DATA_WIDTH/8-1:0] ctrl_be_i,
  input  logic [DATA_WIDTH-1:0]   ctrl_wdata_i,
  output logic                    ctrl_rvalid_o,
  output logic [DATA_WIDTH-1:0]   ctrl_rdata_o,
  output logic                    ctrl_err_o,
  output logic                    secondary_req_o,
  input  logic                    secondary_gnt_i,
  output logic [ADDR_WIDTH-1:0]   secondary_addr_o,
  output logic                    secondary_we_o,
  output logic [DATA_WIDTH/8-1:0] secondary_be_o,
  output logic [DATA_WIDTH-1:0]   secondary_wdata_o,
  input  logic                    secondary_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   secondary_rdata_i
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int OW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

  // ---------------- request path ----------------
  obi_req_t push_ent, head_ent;
  logic     fifo_full, fifo_empty;
  logic     accept, sec_acc;
  logic     head_unused;

  logic [OW-1:0] out_cnt;   // accepted, ctrl response not yet returned
  logic [OW-1:0] iss_cnt;   // granted on secondary, response not yet accepted

  // A pop in the same cycle is deliberately ignored: the grant uses the
  // registered full flag only.
  assign ctrl_gnt_o = !rst_i && ctrl_req_i && !fifo_full &&
                      (out_cnt < OW'(MAX_OUTSTANDING));
  assign accept     = ctrl_req_i && ctrl_gnt_o;

  always_comb begin
    push_ent                        = '0;
    push_ent.addr[ADDR_WIDTH-1:0]   = ctrl_addr_i;
    push_ent.we                     = ctrl_we_i;
    push_ent.be[BE_W-1:0]           = ctrl_be_i;
    push_ent.wdata[DATA_WIDTH-1:0]  = ctrl_wdata_i;
  end

  obi_sync_fifo #(
    .WIDTH ($bits(obi_req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .data_i  (push_ent),
    .pop_i   (sec_acc),
    .data_o  (head_ent),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign secondary_req_o   = !fifo_empty && !rst_i;
  assign sec_acc           = secondary_req_o && secondary_gnt_i;
  assign secondary_addr_o  = head_ent.addr[ADDR_WIDTH-1:0];
  assign secondary_we_o    = head_ent.we;
  assign secondary_be_o    = head_ent.be[BE_W-1:0];
  assign secondary_wdata_o = head_ent.wdata[DATA_WIDTH-1:0];
  // The zero-padding bits of the wide entry are intentionally left unused.
  assign head_unused       = ^head_ent;

  // ---------------- response path ----------------
  logic                  rsp_acc;    // secondary response matched to an issue
  logic                  iss_dec;
  logic                  rsp_fire;   // a ctrl response is produced next cycle
  logic [DATA_WIDTH-1:0] rsp_data;

  // A response with nothing issued is stray (or late after a timeout) and is
  // dropped.
  assign rsp_acc = secondary_rvalid_i && (iss_cnt != '0);

`ifdef OBI_BUF_TIMEOUT_EN
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = {DATA_WIDTH/32{OBI_DEADBEEF}};

  logic [TW-1:0] tmr;
  logic          tmo_fire;
  logic          err_q;

  assign tmo_fire = (iss_cnt != '0) && !rsp_acc &&
                    (tmr == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i)                                      tmr <= '0;
    else if (rsp_acc || tmo_fire || iss_cnt == '0)  tmr <= '0;
    else                                            tmr <= tmr + TW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= tmo_fire;
  end

  assign iss_dec    = rsp_acc || tmo_fire;
  assign rsp_fire   = rsp_acc || tmo_fire;
  assign rsp_data   = tmo_fire ? ERR_DATA : secondary_rdata_i;
  assign ctrl_err_o = err_q;
`else
  logic [TW-1:0] tmo_unused;

  assign tmo_unused = TW'(TIMEOUT_CYCLES);
  assign iss_dec    = rsp_acc;
  assign rsp_fire   = rsp_acc;
  assign rsp_data   = secondary_rdata_i;
  assign ctrl_err_o = 1'b0;
`endif

  // One-stage response register; rdata holds between responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_rvalid_o <= 1'b0;
      ctrl_rdata_o  <= '0;
    end else begin
      ctrl_rvalid_o <= rsp_fire;
      if (rsp_fire) ctrl_rdata_o <= rsp_data;
    end
  end

  // ---------------- counters ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_cnt <= '0;
      iss_cnt <= '0;
    end else begin
      case ({accept, ctrl_rvalid_o})
        2'b10:   out_cnt <= out_cnt + OW'(1);
        2'b01:   out_cnt <= out_cnt - OW'(1);
        default: out_cnt <= out_cnt;
      endcase
      case ({sec_acc, iss_dec})
        2'b10:   iss_cnt <= iss_cnt + OW'(1);
        2'b01:   iss_cnt <= iss_cnt - OW'(1);
        default: iss_cnt <= iss_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_outstanding_buffer.sv
module tb_obi_outstanding_buffer;

  localparam int AW = 32, DW = 32, BW = 4, DEPTH = 2, MAXO = 4, TMO = 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          ctrl_req_i = 1'b0, ctrl_gnt_o;
  logic [AW-1:0] ctrl_addr_i = '0;
  logic          ctrl_we_i = 1'b0;
  logic [BW-1:0] ctrl_be_i = '0;
  logic [DW-1:0] ctrl_wdata_i = '0;
  logic          ctrl_rvalid_o, ctrl_err_o;
  logic [DW-1:0] ctrl_rdata_o;
  logic          secondary_req_o, secondary_gnt_i = 1'b0;
  logic [AW-1:0] secondary_addr_o;
  logic          secondary_we_o;
  logic [BW-1:0] secondary_be_o;
  logic [DW-1:0] secondary_wdata_o;
  logic          secondary_rvalid_i = 1'b0;
  logic [DW-1:0] secondary_rdata_i = '0;

  obi_outstanding_buffer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ctrl_req_i(ctrl_req_i), .ctrl_gnt_o(ctrl_gnt_o),
    .ctrl_addr_i(ctrl_addr_i), .ctrl_we_i(ctrl_we_i), .ctrl_be_i(ctrl_be_i),
    .ctrl_wdata_i(ctrl_wdata_i),
    .ctrl_rvalid_o(ctrl_rvalid_o), .ctrl_rdata_o(ctrl_rdata_o), .ctrl_err_o(ctrl_err_o),
    .secondary_req_o(secondary_req_o), .secondary_gnt_i(secondary_gnt_i),
    .secondary_addr_o(secondary_addr_o), .secondary_we_o(secondary_we_o),
    .secondary_be_o(secondary_be_o), .secondary_wdata_o(secondary_wdata_o),
    .secondary_rvalid_i(secondary_rvalid_i), .secondary_rdata_i(secondary_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge; outputs are sampled
  // 3 units later, well before the next edge.
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    ctrl_req_i = 0; ctrl_addr_i = '0; ctrl_we_i = 0; ctrl_be_i = '0; ctrl_wdata_i = '0;
    secondary_gnt_i = 0; secondary_rvalid_i = 0; secondary_rdata_i = '0;
  endtask

  task automatic do_reset();
    next_cycle(); idle(); rst_i = 1;
    next_cycle();
    next_cycle(); rst_i = 0;
  endtask

  typedef struct {
    bit          req;
    logic [31:0] addr;
    bit          sgnt;
    bit          srv;
    logic [31:0] srd;
    bit          e_gnt;
    bit          e_sreq;
    logic [31:0] e_saddr;
    bit          e_rv;
    logic [31:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(bit req, logic [31:0] addr, bit sgnt, bit srv, logic [31:0] srd,
                              bit eg, bit es, logic [31:0] esa, bit erv, logic [31:0] erd);
    vec_t v;
    v.req = req; v.addr = addr; v.sgnt = sgnt; v.srv = srv; v.srd = srd;
    v.e_gnt = eg; v.e_sreq = es; v.e_saddr = esa; v.e_rv = erv; v.e_rdata = erd;
    return v;
  endfunction

  vec_t tv[15];

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } ent_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // single read, then three in-order reads
    tv[0]  = mk(1, 32'h10, 0, 0, 0,            1, 0, 0,     0, 0);
    tv[1]  = mk(0, 0,      1, 0, 0,            0, 1, 32'h10, 0, 0);
    tv[2]  = mk(0, 0,      0, 0, 0,            0, 0, 0,     0, 0);
    tv[3]  = mk(0, 0,      0, 1, 32'hCAFE0001, 0, 0, 0,     0, 0);
    tv[4]  = mk(0, 0,      0, 0, 0,            0, 0, 0,     1, 32'hCAFE0001);
    tv[5]  = mk(0, 0,      0, 0, 0,            0, 0, 0,     0, 32'hCAFE0001);
    tv[6]  = mk(1, 32'h20, 1, 0, 0,            1, 0, 0,     0, 32'hCAFE0001);
    tv[7]  = mk(1, 32'h24, 1, 0, 0,            1, 1, 32'h20, 0, 32'hCAFE0001);
    tv[8]  = mk(1, 32'h28, 1, 0, 0,            1, 1, 32'h24, 0, 32'hCAFE0001);
    tv[9]  = mk(0, 0,      1, 0, 0,            0, 1, 32'h28, 0, 32'hCAFE0001);
    tv[10] = mk(0, 0,      0, 1, 32'h1,        0, 0, 0,     0, 32'hCAFE0001);
    tv[11] = mk(0, 0,      0, 1, 32'h2,        0, 0, 0,     1, 32'h1);
    tv[12] = mk(0, 0,      0, 1, 32'h3,        0, 0, 0,     1, 32'h2);
    tv[13] = mk(0, 0,      0, 0, 0,            0, 0, 0,     1, 32'h3);
    tv[14] = mk(0, 0,      0, 0, 0,            0, 0, 0,     0, 32'h3);

    // ---- reset state (req held high to see the grant suppressed) ----
    idle(); rst_i = 1; ctrl_req_i = 1;
    next_cycle();
    next_cycle(); #3;
    chk("rst_gnt", ctrl_gnt_o, 0);
    chk("rst_sreq", secondary_req_o, 0);
    chk("rst_rvalid", ctrl_rvalid_o, 0);
    chk("rst_rdata", ctrl_rdata_o, 0);
    chk("rst_err", ctrl_err_o, 0);
    next_cycle(); idle(); rst_i = 0;

    // ---- table-driven vectors ----
    for (int i = 0; i < 15; i++) begin
      next_cycle();
      idle();
      ctrl_req_i = tv[i].req; ctrl_addr_i = tv[i].addr; ctrl_be_i = 4'hF;
      secondary_gnt_i = tv[i].sgnt;
      secondary_rvalid_i = tv[i].srv; secondary_rdata_i = tv[i].srd;
      #3;
      chk($sformatf("tv%0d_gnt", i), ctrl_gnt_o, tv[i].e_gnt);
      chk($sformatf("tv%0d_sreq", i), secondary_req_o, tv[i].e_sreq);
      if (tv[i].e_sreq) chk($sformatf("tv%0d_saddr", i), secondary_addr_o, tv[i].e_saddr);
      chk($sformatf("tv%0d_rvalid", i), ctrl_rvalid_o, tv[i].e_rv);
      chk($sformatf("tv%0d_rdata", i), ctrl_rdata_o, tv[i].e_rdata);
      chk($sformatf("tv%0d_err", i), ctrl_err_o, 0);
    end

    // ---- FIFO full: 4 writes, secondary stalls, DEPTH=2 ----
    do_reset();
    begin
      int idx = 0;
      for (int c = 0; c < 6; c++) begin
        next_cycle(); idle();
        ctrl_req_i = (idx < 4); ctrl_we_i = 1; ctrl_be_i = 4'hF;
        ctrl_addr_i = 32'h100 + 32'(4 * idx); ctrl_wdata_i = 32'hD0 + 32'(idx);
        secondary_gnt_i = (c == 4);
        #3;
        chk($sformatf("full_c%0d_gnt", c), ctrl_gnt_o, (c < 2 || c == 5) ? 1 : 0);
        if (c >= 2 && c <= 4) begin
          chk($sformatf("full_c%0d_hold_addr", c), secondary_addr_o, 32'h100);
          chk($sformatf("full_c%0d_hold_wdata", c), secondary_wdata_o, 32'hD0);
          chk($sformatf("full_c%0d_we", c), secondary_we_o, 1);
        end
        if (c == 5) chk("full_c5_head", secondary_addr_o, 32'h104);
        if (ctrl_gnt_o) idx++;
      end
    end

    // ---- outstanding limit: MAX=4, secondary always grants ----
    do_reset();
    for (int c = 0; c < 10; c++) begin
      next_cycle(); idle();
      ctrl_req_i = 1; ctrl_addr_i = 32'h200 + 32'(4 * c); ctrl_be_i = 4'hF;
      secondary_gnt_i = 1;
      secondary_rvalid_i = (c == 7); secondary_rdata_i = 32'hA5;
      #3;
      chk($sformatf("lim_c%0d_gnt", c), ctrl_gnt_o, (c < 4 || c == 9) ? 1 : 0);
      if (c == 8) begin
        chk("lim_rvalid", ctrl_rvalid_o, 1);
        chk("lim_rdata", ctrl_rdata_o, 32'hA5);
      end
      if (c >= 4 && c <= 8) ctrl_req_i = 1;
    end

    // ---- reset mid-operation ----
    do_reset();
    for (int c = 0; c < 12; c++) begin
      next_cycle(); idle();
      secondary_gnt_i = 1; ctrl_be_i = 4'hF; ctrl_addr_i = 32'h400 + 32'(c);
      ctrl_req_i = (c < 2) || (c >= 4 && c <= 5) || (c >= 7);
      rst_i = (c == 4 || c == 5);
      secondary_rvalid_i = (c == 6); secondary_rdata_i = 32'h55;
      #3;
      if (c == 4 || c == 5) begin
        chk($sformatf("mid_rst_c%0d_gnt", c), ctrl_gnt_o, 0);
        chk($sformatf("mid_rst_c%0d_sreq", c), secondary_req_o, 0);
      end
      if (c == 6 || c == 7) chk($sformatf("mid_rst_c%0d_rvalid", c), ctrl_rvalid_o, 0);
      if (c >= 7) chk($sformatf("mid_rst_c%0d_gnt", c), ctrl_gnt_o, (c < 11) ? 1 : 0);
    end
    rst_i = 0;

`ifdef OBI_BUF_TIMEOUT_EN
    // ---- timeout: grant, never respond ----
    do_reset();
    next_cycle(); idle(); ctrl_req_i = 1; ctrl_addr_i = 32'h300; ctrl_be_i = 4'hF;
    #3; chk("tmo_gnt", ctrl_gnt_o, 1);
    next_cycle(); idle(); secondary_gnt_i = 1;
    #3; chk("tmo_sreq", secondary_req_o, 1);
    begin
      int seen = -1;
      for (int k = 2; k < 22 && seen < 0; k++) begin
        next_cycle(); idle();
        #3;
        if (ctrl_rvalid_o) begin
          seen = k;
          chk("tmo_err", ctrl_err_o, 1);
          chk("tmo_rdata", ctrl_rdata_o, 32'hDEADBEEF);
        end
      end
      chk("tmo_cycle", seen, 10);
      next_cycle(); idle(); secondary_rvalid_i = 1; secondary_rdata_i = 32'h77;
      #3; chk("tmo_one_cycle", ctrl_rvalid_o, 0);
      next_cycle(); idle();
      #3; chk("tmo_late_discard", ctrl_rvalid_o, 0);
    end
`endif

    // ---- randomized traffic against a queue-based reference model ----
    do_reset();
    begin
      ent_t        q[$];
      ent_t        e;
      int          outst = 0, issued = 0, wait_cnt = 0;
      bit          rsp_pend = 0;
      logic [31:0] last_rdata = 0;
      bit          exp_gnt, exp_sreq, acc, pop, racc, rv_now;
      for (int n = 0; n < 400; n++) begin
        next_cycle(); idle();
        ctrl_req_i   = ($urandom_range(9) < 6);
        ctrl_addr_i  = $urandom & 32'hFFFF_FFFC;
        ctrl_we_i    = $urandom_range(1);
        ctrl_be_i    = 4'($urandom);
        ctrl_wdata_i = $urandom;
        secondary_gnt_i = ($urandom_range(9) < 6);
        if (issued > 0) secondary_rvalid_i = ($urandom_range(1) == 1) || (wait_cnt >= 3);
        else            secondary_rvalid_i = ($urandom_range(9) == 0);
        secondary_rdata_i = $urandom;
        #3;
        exp_gnt  = ctrl_req_i && (q.size() < DEPTH) && (outst < MAXO);
        exp_sreq = (q.size() > 0);
        chk("rnd_gnt", ctrl_gnt_o, exp_gnt);
        chk("rnd_sreq", secondary_req_o, exp_sreq);
        if (exp_sreq) begin
          chk("rnd_saddr", secondary_addr_o, q[0].addr);
          chk("rnd_swe", secondary_we_o, q[0].we);
          chk("rnd_sbe", secondary_be_o, q[0].be);
          chk("rnd_swdata", secondary_wdata_o, q[0].wdata);
        end
        chk("rnd_rvalid", ctrl_rvalid_o, rsp_pend);
        chk("rnd_rdata", ctrl_rdata_o, last_rdata);
        chk("rnd_err", ctrl_err_o, 0);
        // advance the model across the coming edge
        rv_now = rsp_pend;
        acc    = exp_gnt;
        pop    = exp_sreq && secondary_gnt_i;
        racc   = secondary_rvalid_i && (issued > 0);
        if (issued > 0 && !racc) wait_cnt++; else wait_cnt = 0;
        if (pop) void'(q.pop_front());
        if (acc) begin
          e.addr = ctrl_addr_i; e.we = ctrl_we_i; e.be = ctrl_be_i; e.wdata = ctrl_wdata_i;
          q.push_back(e);
        end
        if (pop)  issued++;
        if (racc) issued--;
        if (acc)    outst++;
        if (rv_now) outst--;
        rsp_pend = racc;
        if (racc) last_rdata = secondary_rdata_i;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
